// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
//   Bundles the signals exchanged between the 5-stage RV32I pipeline and its
//   hazard/stall controller.
//
//   master : pipeline side. Drives hazard sources and the D-cache completion.
//            Receives the stage enables, flushes, D-cache request and status.
//   slave  : the controller (pipeline_stall_ctrl).
//
//   Hazard sources: rs1_id, rs2_id, use_rs1, use_rs2, opcode_id, ex_rd,
//                   ex_reg_write, ex_mem_read, mem_rd, mem_mem_read,
//                   mem_access, dcache_done, ex_mispredict, halt_req
//   Controls      : dcache_req, pc_write, ifid_write, ifid_flush, idex_write,
//                   idex_flush, exmem_write, memwb_write, halted
//   Status        : stall_cycles, state_dbg (0=RUN, 1=DWAIT, 2=HALT)
//   HAZARD_STATS_EN adds load_use_cnt, dcache_wait_cnt and flush_cnt.
//
//   D-cache handshake: dcache_req is a one-cycle pulse issued in RUN for a
//   MEM-stage load/store. dcache_done is a one-cycle completion pulse that may
//   arrive in the same cycle as the request (hit) or any later cycle (miss).
//   The MEM-stage access is held in place until dcache_done is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1;
  logic             use_rs2;
  logic [6:0]       opcode_id;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_mem_read;
  logic             mem_access;
  logic             dcache_done;
  logic             ex_mispredict;
  logic             halt_req;

  logic             dcache_req;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             memwb_write;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       state_dbg;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] dcache_wait_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport master (
    output rs1_id, rs2_id, use_rs1, use_rs2, opcode_id, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_mem_read, mem_access, dcache_done,
           ex_mispredict, halt_req,
`ifdef HAZARD_STATS_EN
    input  load_use_cnt, dcache_wait_cnt, flush_cnt,
`endif
    input  dcache_req, pc_write, ifid_write, ifid_flush, idex_write,
           idex_flush, exmem_write, memwb_write, halted, stall_cycles,
           state_dbg
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1, use_rs2, opcode_id, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_mem_read, mem_access, dcache_done,
           ex_mispredict, halt_req,
`ifdef HAZARD_STATS_EN
    output load_use_cnt, dcache_wait_cnt, flush_cnt,
`endif
    output dcache_req, pc_write, ifid_write, ifid_flush, idex_write,
           idex_flush, exmem_write, memwb_write, halted, stall_cycles,
           state_dbg
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Hazard/stall controller for the 5-stage RV32I pipeline. Sits beside ID/EX
//   and drives every pipeline-register enable and flush. Covers the hazards
//   forwarding cannot: load-use, ECALL reading x17 while it is still being
//   produced, D-cache miss freeze and EX branch mispredict. Owns the D-cache
//   request FSM (RUN / DWAIT / HALT) and a saturating stall-cycle counter.
//
// Ports
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-low
//   bus   : pipeline_stall_ctrl_if.slave (hazard inputs, enables/flushes,
//           dcache_req, halted, stall_cycles, state_dbg)
//
// Parameters
//   CNT_W     : width of the saturating counters
//   ECALL_REG : register ECALL reads as its argument (x17)
//
// Optional feature macro: HAZARD_STATS_EN adds the saturating counters
//   load_use_cnt, dcache_wait_cnt and flush_cnt to the interface.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module pipeline_stall_ctrl #(
  parameter int CNT_W     = 32,
  parameter int ECALL_REG = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [6:0]       OP_ECALL = 7'b1110011;
  localparam logic [4:0]       ECALL_RD = 5'(ECALL_REG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic ecall_hz;
  logic freeze;
  logic active;     // out of reset and not halted: hazard logic is live

  logic dcache_req_o, pc_write_o, ifid_write_o, ifid_flush_o;
  logic idex_write_o, idex_flush_o, exmem_write_o, memwb_write_o, halted_o;

  assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.use_rs1 && (bus.rs1_id == bus.ex_rd)) ||
                     (bus.use_rs2 && (bus.rs2_id == bus.ex_rd)));

  // ECALL reads x17 in ID; an ALU producer in EX or a load in MEM cannot be
  // forwarded into the ECALL decode path, so the ECALL waits one cycle.
  assign ecall_hz = (bus.opcode_id == OP_ECALL) &&
                    ((bus.ex_reg_write && (bus.ex_rd == ECALL_RD)) ||
                     (bus.mem_mem_read && (bus.mem_rd == ECALL_RD)));

  // A hit (done in the request cycle) never freezes; in DWAIT the cycle that
  // carries dcache_done is already a moving cycle.
  assign freeze = ((state_q == RUN)   && bus.mem_access && !bus.dcache_done) ||
                  ((state_q == DWAIT) && !bus.dcache_done);

  assign active = reset && (state_q != HALT);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.halt_req)                              state_d = HALT;
        else if (bus.mem_access && !bus.dcache_done)   state_d = DWAIT;
      end
      DWAIT: begin
        if (bus.halt_req)                              state_d = HALT;
        else if (bus.dcache_done)                      state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Enables and flushes, highest priority first
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_write_o = 1'b1;
    memwb_write_o = 1'b1;
    halted_o      = 1'b0;
    dcache_req_o  = reset && (state_q == RUN) && bus.mem_access;

    if (!reset || (state_q == HALT) || freeze) begin
      // Everything holds; a pending mispredict stays in EX until unfrozen.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
      memwb_write_o = 1'b0;
      halted_o      = reset && (state_q == HALT);
    end else if (bus.ex_mispredict) begin
      // The ID instruction is on the wrong path, so any stall it asked for
      // is moot: squash IF/ID and ID/EX and redirect.
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
    end else if (load_use || ecall_hz) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (active && !pc_write_o && (stall_cycles_q != CNT_MAX))
      stall_cycles_d = stall_cycles_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
  logic [CNT_W-1:0] dcache_wait_cnt_q, dcache_wait_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    load_use_cnt_d    = load_use_cnt_q;
    dcache_wait_cnt_d = dcache_wait_cnt_q;
    flush_cnt_d       = flush_cnt_q;
    if (active && freeze && (dcache_wait_cnt_q != CNT_MAX))
      dcache_wait_cnt_d = dcache_wait_cnt_q + CNT_ONE;
    if (active && !freeze && bus.ex_mispredict && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    if (active && !freeze && !bus.ex_mispredict && (load_use || ecall_hz) &&
        (load_use_cnt_q != CNT_MAX))
      load_use_cnt_d = load_use_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      load_use_cnt_q    <= '0;
      dcache_wait_cnt_q <= '0;
      flush_cnt_q       <= '0;
    end else begin
      load_use_cnt_q    <= load_use_cnt_d;
      dcache_wait_cnt_q <= dcache_wait_cnt_d;
      flush_cnt_q       <= flush_cnt_d;
    end
  end

  assign bus.load_use_cnt    = load_use_cnt_q;
  assign bus.dcache_wait_cnt = dcache_wait_cnt_q;
  assign bus.flush_cnt       = flush_cnt_q;
`endif

  assign bus.dcache_req   = dcache_req_o;
  assign bus.pc_write     = pc_write_o;
  assign bus.ifid_write   = ifid_write_o;
  assign bus.ifid_flush   = ifid_flush_o;
  assign bus.idex_write   = idex_write_o;
  assign bus.idex_flush   = idex_flush_o;
  assign bus.exmem_write  = exmem_write_o;
  assign bus.memwb_write  = memwb_write_o;
  assign bus.halted       = halted_o;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Directed bench for pipeline_stall_ctrl. Inputs change on the falling edge,
//   combinational outputs are sampled 1ns later, registered state is sampled
//   at the following falling edge. Output vector bit order:
//   {dcache_req, pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
//    exmem_write, memwb_write, halted}
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_pipeline_stall_ctrl;

  localparam logic [8:0] O_ZERO   = 9'b000000000;
  localparam logic [8:0] O_NORMAL = 9'b011010110;
  localparam logic [8:0] O_HIT    = 9'b111010110;
  localparam logic [8:0] O_STALL  = 9'b000011110;
  localparam logic [8:0] O_STALLQ = 9'b100011110;
  localparam logic [8:0] O_FLUSH  = 9'b011111110;
  localparam logic [8:0] O_FRZREQ = 9'b100000000;
  localparam logic [8:0] O_HALT   = 9'b000000001;
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DWAIT  = 2'd1;
  localparam logic [1:0] S_HALT   = 2'd2;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(32)) bif ();

  pipeline_stall_ctrl #(.CNT_W(32), .ECALL_REG(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  function automatic logic [8:0] outs();
    return {bif.dcache_req, bif.pc_write, bif.ifid_write, bif.ifid_flush,
            bif.idex_write, bif.idex_flush, bif.exmem_write, bif.memwb_write,
            bif.halted};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bif.rs1_id = 5'd0;  bif.rs2_id = 5'd0;
    bif.use_rs1 = 1'b0; bif.use_rs2 = 1'b0;
    bif.opcode_id = 7'd0;
    bif.ex_rd = 5'd0;   bif.ex_reg_write = 1'b0; bif.ex_mem_read = 1'b0;
    bif.mem_rd = 5'd0;  bif.mem_mem_read = 1'b0; bif.mem_access = 1'b0;
    bif.dcache_done = 1'b0; bif.ex_mispredict = 1'b0; bif.halt_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bif.mem_access = 1'b1; bif.ex_mispredict = 1'b1; bif.halt_req = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_ZERO) begin tests_failed++;
      $display("FAIL reset_outs: got %b expected %b", outs(), O_ZERO); end
    @(negedge clk);
    tests_run++;
    if (bif.state_dbg !== S_RUN) begin tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", bif.state_dbg, S_RUN); end
    tests_run++;
    if (bif.stall_cycles !== 32'd0) begin tests_failed++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", bif.stall_cycles); end
    reset = 1'b1;
    idle();
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL reset_release: got %b expected %b", outs(), O_NORMAL); end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in EX, add x6,x5,x1 in ID
    bif.ex_mem_read = 1'b1; bif.ex_reg_write = 1'b1; bif.ex_rd = 5'd5;
    bif.rs1_id = 5'd5; bif.use_rs1 = 1'b1; bif.rs2_id = 5'd1; bif.use_rs2 = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_STALL) begin tests_failed++;
      $display("FAIL load_use_rs1: got %b expected %b", outs(), O_STALL); end
    @(negedge clk);
    // load moved to MEM and hits
    idle();
    bif.mem_mem_read = 1'b1; bif.mem_rd = 5'd5; bif.mem_access = 1'b1; bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_HIT) begin tests_failed++;
      $display("FAIL load_use_next: got %b expected %b", outs(), O_HIT); end
    tests_run++;
    if (bif.stall_cycles !== 32'd1) begin tests_failed++;
      $display("FAIL load_use_stall_cnt: got %0d expected 1", bif.stall_cycles); end
    @(negedge clk);
    idle();
    bif.ex_mem_read = 1'b1; bif.ex_rd = 5'd0; bif.rs1_id = 5'd0; bif.use_rs1 = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL load_use_x0: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    bif.ex_rd = 5'd7; bif.rs1_id = 5'd7; bif.rs2_id = 5'd7;
    bif.use_rs1 = 1'b0; bif.use_rs2 = 1'b0;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL load_use_unused_src: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    bif.use_rs2 = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_STALL) begin tests_failed++;
      $display("FAIL load_use_rs2: got %b expected %b", outs(), O_STALL); end
    @(negedge clk);
    idle();
    bif.ex_reg_write = 1'b1; bif.ex_rd = 5'd7; bif.rs1_id = 5'd7; bif.use_rs1 = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL alu_fwd_no_stall: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (bif.stall_cycles !== 32'd2) begin tests_failed++;
      $display("FAIL load_use_stall_cnt2: got %0d expected 2", bif.stall_cycles); end
  endtask

  task automatic test_dcache_miss();
    do_reset();
    bif.mem_access = 1'b1; bif.mem_mem_read = 1'b1; bif.mem_rd = 5'd3;
    #1;
    tests_run++;
    if (outs() !== O_FRZREQ) begin tests_failed++;
      $display("FAIL miss_req: got %b expected %b", outs(), O_FRZREQ); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (outs() !== O_ZERO) begin tests_failed++;
        $display("FAIL miss_freeze_%0d: got %b expected %b", i, outs(), O_ZERO); end
      tests_run++;
      if (bif.state_dbg !== S_DWAIT) begin tests_failed++;
        $display("FAIL miss_dwait_%0d: got %0d expected %0d", i, bif.state_dbg, S_DWAIT); end
    end
    @(negedge clk);
    bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL miss_done: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (bif.state_dbg !== S_RUN) begin tests_failed++;
      $display("FAIL miss_back_run: got %0d expected %0d", bif.state_dbg, S_RUN); end
    tests_run++;
    if (bif.stall_cycles !== 32'd4) begin tests_failed++;
      $display("FAIL miss_stall_cnt: got %0d expected 4", bif.stall_cycles); end
  endtask

  task automatic test_hit();
    do_reset();
    bif.mem_access = 1'b1; bif.mem_mem_read = 1'b1; bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_HIT) begin tests_failed++;
      $display("FAIL hit_outs: got %b expected %b", outs(), O_HIT); end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (bif.state_dbg !== S_RUN) begin tests_failed++;
      $display("FAIL hit_state: got %0d expected %0d", bif.state_dbg, S_RUN); end
    tests_run++;
    if (bif.stall_cycles !== 32'd0) begin tests_failed++;
      $display("FAIL hit_stall_cnt: got %0d expected 0", bif.stall_cycles); end
  endtask

  task automatic test_mispredict();
    do_reset();
    bif.ex_mispredict = 1'b1;
    bif.ex_mem_read = 1'b1; bif.ex_rd = 5'd9; bif.rs1_id = 5'd9; bif.use_rs1 = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_FLUSH) begin tests_failed++;
      $display("FAIL mispredict_over_load_use: got %b expected %b", outs(), O_FLUSH); end
    @(negedge clk);
    idle();
    bif.ex_mispredict = 1'b1; bif.mem_access = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_FRZREQ) begin tests_failed++;
      $display("FAIL mispredict_in_freeze: got %b expected %b", outs(), O_FRZREQ); end
    @(negedge clk);
    bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_FLUSH) begin tests_failed++;
      $display("FAIL mispredict_after_freeze: got %b expected %b", outs(), O_FLUSH); end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (bif.stall_cycles !== 32'd1) begin tests_failed++;
      $display("FAIL mispredict_stall_cnt: got %0d expected 1", bif.stall_cycles); end
  endtask

  task automatic test_ecall();
    do_reset();
    bif.opcode_id = OP_ECALL; bif.ex_reg_write = 1'b1; bif.ex_rd = 5'd17;
    #1;
    tests_run++;
    if (outs() !== O_STALL) begin tests_failed++;
      $display("FAIL ecall_ex_x17: got %b expected %b", outs(), O_STALL); end
    @(negedge clk);
    idle();
    bif.opcode_id = OP_ECALL; bif.mem_mem_read = 1'b1; bif.mem_rd = 5'd17;
    bif.mem_access = 1'b1; bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_STALLQ) begin tests_failed++;
      $display("FAIL ecall_mem_load_x17: got %b expected %b", outs(), O_STALLQ); end
    @(negedge clk);
    idle();
    bif.opcode_id = OP_ECALL;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL ecall_wb_only: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    bif.ex_reg_write = 1'b1; bif.ex_rd = 5'd16;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL ecall_other_rd: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    idle();
    bif.opcode_id = OP_ECALL; bif.mem_rd = 5'd17;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL ecall_mem_non_load: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    idle();
    bif.opcode_id = 7'b0010011; bif.ex_reg_write = 1'b1; bif.ex_rd = 5'd17;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL non_ecall_x17: got %b expected %b", outs(), O_NORMAL); end
    @(negedge clk);
    idle();
    #1;
    tests_run++;
    if (bif.stall_cycles !== 32'd2) begin tests_failed++;
      $display("FAIL ecall_stall_cnt: got %0d expected 2", bif.stall_cycles); end
  endtask

  task automatic test_halt();
    do_reset();
    bif.mem_access = 1'b1;
    @(negedge clk);
    bif.halt_req = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_ZERO) begin tests_failed++;
      $display("FAIL halt_req_in_dwait: got %b expected %b", outs(), O_ZERO); end
    @(negedge clk);
    bif.halt_req = 1'b0;
    #1;
    tests_run++;
    if (outs() !== O_HALT) begin tests_failed++;
      $display("FAIL halted_outs: got %b expected %b", outs(), O_HALT); end
    tests_run++;
    if (bif.state_dbg !== S_HALT) begin tests_failed++;
      $display("FAIL halted_state: got %0d expected %0d", bif.state_dbg, S_HALT); end
    @(negedge clk);
    idle();
    bif.ex_mispredict = 1'b1; bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_HALT) begin tests_failed++;
      $display("FAIL halt_sticky: got %b expected %b", outs(), O_HALT); end
    tests_run++;
    if (bif.stall_cycles !== 32'd2) begin tests_failed++;
      $display("FAIL halt_stall_cnt: got %0d expected 2", bif.stall_cycles); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (outs() !== O_ZERO) begin tests_failed++;
      $display("FAIL reset_in_halt: got %b expected %b", outs(), O_ZERO); end
    @(negedge clk);
    reset = 1'b1;
    idle();
    #1;
    tests_run++;
    if (bif.state_dbg !== S_RUN) begin tests_failed++;
      $display("FAIL halt_reset_state: got %0d expected %0d", bif.state_dbg, S_RUN); end
    tests_run++;
    if (bif.stall_cycles !== 32'd0) begin tests_failed++;
      $display("FAIL halt_reset_cnt: got %0d expected 0", bif.stall_cycles); end
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL halt_reset_outs: got %b expected %b", outs(), O_NORMAL); end
  endtask

  task automatic test_reset_mid_dwait();
    do_reset();
    bif.mem_access = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bif.state_dbg !== S_DWAIT) begin tests_failed++;
      $display("FAIL mid_dwait_state: got %0d expected %0d", bif.state_dbg, S_DWAIT); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (outs() !== O_ZERO) begin tests_failed++;
      $display("FAIL mid_dwait_reset_outs: got %b expected %b", outs(), O_ZERO); end
    @(negedge clk);
    reset = 1'b1;
    bif.mem_access = 1'b0;
    #1;
    tests_run++;
    if (outs() !== O_NORMAL) begin tests_failed++;
      $display("FAIL mid_dwait_no_reissue: got %b expected %b", outs(), O_NORMAL); end
    tests_run++;
    if (bif.state_dbg !== S_RUN) begin tests_failed++;
      $display("FAIL mid_dwait_run: got %0d expected %0d", bif.state_dbg, S_RUN); end
    @(negedge clk);
    bif.mem_access = 1'b1; bif.dcache_done = 1'b1;
    #1;
    tests_run++;
    if (outs() !== O_HIT) begin tests_failed++;
      $display("FAIL mid_dwait_new_req: got %b expected %b", outs(), O_HIT); end
    @(negedge clk);
    idle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_dcache_miss();
    test_hit();
    test_mispredict();
    test_ecall();
    test_halt();
    test_reset_mid_dwait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
